// File: rtl/ifetch_unit.sv
// Purpose: RISC-V instruction fetch stage; holds the PC, fetches over req/gnt/rvalid and computes next PC.
// Latency: 3 cycles per instruction minimum (REQ+gnt, WAIT+rvalid, HOLD+ready), +1 per stall cycle.
// Backpressure: request held with stable address until gnt; instruction held until inst_ready retires it.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  input  logic        inst_ready,
  input  logic [2:0]  NPCOp,
  input  logic [31:0] imm,
  input  logic [31:0] alu_res,
  output logic        trap,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    TRAP = 3'd4
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        inst_vld_q;
  logic        trap_q;
  logic [31:0] instret_q;
  logic [31:0] npc;

  // JALR clears bit 0 of the target, so alu_res[0] never reaches the PC.
  logic unused_alu_lsb;
  assign unused_alu_lsb = alu_res[0];

  // Next-PC selection from the decoder's NPCOp; unknown codes fall back to sequential.
  always_comb begin
    npc = pc_q + 32'd4;
    case (NPCOp)
      3'b001, 3'b010: npc = pc_q + imm;
      3'b100:         npc = {alu_res[31:1], 1'b0};
      default:        npc = pc_q + 32'd4;
    endcase
  end

  // Fetch FSM: request, wait for response, hold until retire, or park in TRAP.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= NOP;
      inst_vld_q <= 1'b0;
      trap_q     <= 1'b0;
      instret_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_gnt) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            inst_q     <= imem_rdata;
            inst_vld_q <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            instret_q  <= instret_q + 32'd1;
            inst_vld_q <= 1'b0;
            if (npc[1:0] != 2'b00) begin
              trap_q <= 1'b1;
              state  <= TRAP;
            end else begin
              pc_q  <= npc;
              state <= REQ;
            end
          end
        end
        TRAP: begin
          inst_vld_q <= 1'b0;
          trap_q     <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_req   = (state == REQ);
  assign imem_addr  = pc_q;
  assign pc_out     = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_vld_q;
  assign trap       = trap_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Purpose: directed self-checking bench for ifetch_unit.
// Latency: drives one fetch per helper call, sampling on the falling edge.
// Backpressure: grant stalls and mid-WAIT reset exercised explicitly.
module tb_ifetch_unit;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic        inst_ready;
  logic [2:0]  NPCOp;
  logic [31:0] imm;
  logic [31:0] alu_res;
  logic        trap;
  logic [31:0] instret;

  int checks;
  int failures;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .pc_out(pc_out),
    .inst_ready(inst_ready), .NPCOp(NPCOp), .imm(imm), .alu_res(alu_res),
    .trap(trap), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: hold reset across two rising edges, leave reset asserted.
  task automatic apply_reset();
    rstn = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    NPCOp = 3'b000; imm = 32'd0; alu_res = 32'd0; imem_rdata = 32'd0;
    repeat (2) @(negedge clk);
  endtask

  // Stimulus only: one full fetch/retire; returns what was observed.
  task automatic run_fetch(input logic [31:0] rdata, input int gnt_wait,
                           input logic [2:0] op, input logic [31:0] imm_v,
                           input logic [31:0] alu_v,
                           output logic [31:0] addr_seen, output logic stable,
                           output logic vld_wait, output logic vld_hold,
                           output logic vld_after, output logic [31:0] inst_seen,
                           output logic [31:0] pc_seen, output logic ok);
    int n;
    ok = 1'b1; stable = 1'b1; addr_seen = 32'hxxxx_xxxx;
    vld_wait = 1'bx; vld_hold = 1'bx; vld_after = 1'bx;
    inst_seen = 32'hxxxx_xxxx; pc_seen = 32'hxxxx_xxxx;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    addr_seen = imem_addr;
    repeat (gnt_wait) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== addr_seen) stable = 1'b0;
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    vld_wait = inst_valid;
    imem_rvalid = 1'b1; imem_rdata = rdata;
    @(negedge clk);
    imem_rvalid = 1'b0;
    vld_hold = inst_valid; inst_seen = inst; pc_seen = pc_out;
    NPCOp = op; imm = imm_v; alu_res = alu_v; inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    vld_after = inst_valid;
  endtask

  logic [31:0] a, i_s, p_s;
  logic st, vw, vh, va, ok;

  task automatic test_reset();
    apply_reset();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (inst !== 32'h0000_0013) begin failures++; $display("FAIL rst_inst got=%h exp=00000013", inst); end
    checks++; if (inst_valid !== 1'b0 || trap !== 1'b0) begin failures++; $display("FAIL rst_vld_trap got=%b%b exp=00", inst_valid, trap); end
    checks++; if (instret !== 32'd0 || pc_out !== 32'd0) begin failures++; $display("FAIL rst_cnt_pc got=%h/%h exp=0/0", instret, pc_out); end
    rstn = 1'b1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", imem_req); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      run_fetch(32'h0010_0093 + 32'(i), 0, 3'b000, 32'd0, 32'd0, a, st, vw, vh, va, i_s, p_s, ok);
      checks++; if (!ok || a !== 32'(4 * i)) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, a, 32'(4 * i)); end
      checks++; if (vw !== 1'b0 || vh !== 1'b1 || va !== 1'b0) begin failures++; $display("FAIL seq_vld%0d got=%b%b%b exp=010", i, vw, vh, va); end
      checks++; if (i_s !== 32'h0010_0093 + 32'(i) || p_s !== 32'(4 * i)) begin failures++; $display("FAIL seq_inst%0d got=%h/%h exp=%h/%h", i, i_s, p_s, 32'h0010_0093 + 32'(i), 32'(4 * i)); end
    end
    checks++; if (instret !== 32'd3) begin failures++; $display("FAIL seq_instret got=%0d exp=3", instret); end
  endtask

  task automatic test_gnt_stall();
    apply_reset(); rstn = 1'b1;
    run_fetch(32'h0000_0013, 5, 3'b000, 32'd0, 32'd0, a, st, vw, vh, va, i_s, p_s, ok);
    checks++; if (!ok || a !== 32'd0 || st !== 1'b1) begin failures++; $display("FAIL stall_hold got addr=%h stable=%b exp addr=0 stable=1", a, st); end
    run_fetch(32'h0000_0013, 0, 3'b000, 32'd0, 32'd0, a, st, vw, vh, va, i_s, p_s, ok);
    checks++; if (!ok || a !== 32'd4) begin failures++; $display("FAIL stall_next got=%h exp=4", a); end
  endtask

  task automatic test_branch_jump();
    apply_reset(); rstn = 1'b1;
    run_fetch(32'h0000_006f, 0, 3'b010, 32'h0000_0100, 32'd0, a, st, vw, vh, va, i_s, p_s, ok);
    run_fetch(32'h0000_0063, 0, 3'b001, 32'hFFFF_FFF0, 32'd0, a, st, vw, vh, va, i_s, p_s, ok);
    checks++; if (!ok || a !== 32'h100) begin failures++; $display("FAIL jump_to100 got=%h exp=100", a); end
    run_fetch(32'h0000_006f, 0, 3'b010, 32'h0000_0010, 32'd0, a, st, vw, vh, va, i_s, p_s, ok);
    checks++; if (!ok || a !== 32'hF0) begin failures++; $display("FAIL branch_neg got=%h exp=f0", a); end
    run_fetch(32'h0000_006f, 0, 3'b010, 32'h0000_0020, 32'd0, a, st, vw, vh, va, i_s, p_s, ok);
    checks++; if (!ok || a !== 32'h100) begin failures++; $display("FAIL jump_back got=%h exp=100", a); end
    run_fetch(32'h0000_0013, 0, 3'b000, 32'd0, 32'd0, a, st, vw, vh, va, i_s, p_s, ok);
    checks++; if (!ok || a !== 32'h120) begin failures++; $display("FAIL jump_pos got=%h exp=120", a); end
  endtask

  task automatic test_jalr_trap();
    logic req_seen;
    run_fetch(32'h0000_0067, 0, 3'b100, 32'd0, 32'h0000_2001, a, st, vw, vh, va, i_s, p_s, ok);
    run_fetch(32'h0000_0013, 0, 3'b011, 32'd0, 32'd0, a, st, vw, vh, va, i_s, p_s, ok);
    checks++; if (!ok || a !== 32'h2000) begin failures++; $display("FAIL jalr_lsb got=%h exp=2000", a); end
    run_fetch(32'h0000_0067, 0, 3'b100, 32'd0, 32'h0000_2002, a, st, vw, vh, va, i_s, p_s, ok);
    checks++; if (!ok || a !== 32'h2004) begin failures++; $display("FAIL badop_plus4 got=%h exp=2004", a); end
    checks++; if (trap !== 1'b1 || inst_valid !== 1'b0) begin failures++; $display("FAIL trap_set got trap=%b vld=%b exp 1/0", trap, inst_valid); end
    req_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || trap !== 1'b1) req_seen = 1'b1;
    end
    checks++; if (req_seen !== 1'b0) begin failures++; $display("FAIL trap_sticky got=%b exp=0", req_seen); end
    checks++; if (pc_out !== 32'h2004) begin failures++; $display("FAIL trap_pc got=%h exp=2004", pc_out); end
  endtask

  task automatic test_reset_in_wait();
    apply_reset(); rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; rstn = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b0; rstn = 1'b1;
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h13 || trap !== 1'b0) begin failures++; $display("FAIL rstwait_drop got vld=%b inst=%h trap=%b exp 0/00000013/0", inst_valid, inst, trap); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rstwait_idle got=%b exp=0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++; $display("FAIL rstwait_req got=%b/%h exp=1/0", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    apply_reset(); rstn = 1'b1;
    run_fetch(32'h0000_006f, 0, 3'b010, 32'hFFFF_FFFC, 32'd0, a, st, vw, vh, va, i_s, p_s, ok);
    run_fetch(32'h0000_0013, 0, 3'b000, 32'd0, 32'd0, a, st, vw, vh, va, i_s, p_s, ok);
    checks++; if (!ok || a !== 32'hFFFF_FFFC) begin failures++; $display("FAIL pc_top got=%h exp=fffffffc", a); end
    dut.instret_q = 32'hFFFF_FFFF;
    run_fetch(32'h0000_0013, 0, 3'b000, 32'd0, 32'd0, a, st, vw, vh, va, i_s, p_s, ok);
    checks++; if (!ok || a !== 32'd0) begin failures++; $display("FAIL pc_wrap got=%h exp=0", a); end
    checks++; if (instret !== 32'd0) begin failures++; $display("FAIL instret_wrap got=%h exp=0", instret); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rstn = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    inst_ready = 1'b0; NPCOp = 3'b000; imm = 32'd0; alu_res = 32'd0;
    test_reset();
    test_sequential();
    test_gnt_stall();
    test_branch_jump();
    test_jalr_trap();
    test_reset_in_wait();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
